// File: rtl/ahb_bm_arbiter_if.sv
// rtl/ahb_bm_arbiter_if.sv - bus request/grant and config port bundle for the bus-master arbiter
interface ahb_bm_arbiter_if #(
    parameter int NMST = 8
);
    logic [NMST-1:0] HBUSREQ;
    logic [1:0]      HTRANS;
    logic            HREADY;
    logic [NMST-1:0] HGRANT;
    logic [2:0]      HMASTER;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;

    modport slave (
        input  HBUSREQ, HTRANS, HREADY, cfg_we, cfg_addr, cfg_wdata,
        output HGRANT, HMASTER, cfg_rdata
    );

    modport master (
        output HBUSREQ, HTRANS, HREADY, cfg_we, cfg_addr, cfg_wdata,
        input  HGRANT, HMASTER, cfg_rdata
    );
endinterface

// File: rtl/ahb_bm_arbiter.sv
// rtl/ahb_bm_arbiter.sv - round-robin bus-master arbiter with per-tenure beat limit
module ahb_bm_arbiter #(
    parameter int NMST         = 8,
    parameter int DEF_MAXBEATS = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_bm_arbiter_if.slave   bus
);
    localparam int IW = (NMST > 1) ? $clog2(NMST) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OWN  = 2'b01
    } state_t;

    state_t          state, state_nx;
    logic [NMST-1:0] grant, grant_nx;
    logic [NMST-1:0] mask;
    logic [NMST-1:0] elig;
    logic [NMST-1:0] owner_bit;
    logic [2:0]      hmaster, hmaster_nx;
    logic [IW-1:0]   last, last_nx;
    logic [IW-1:0]   cand, winner;
    logic [7:0]      beat_cnt, beat_cnt_nx;
    logic [7:0]      maxbeats;
    logic [8:0]      beat_sum;
    logic            found;
    logic            limit_hit;
    logic            others;
    logic            release_now;

    assign elig      = bus.HBUSREQ & mask;
    assign owner_bit = NMST'(1) << last;

    // Search starts just above the last owner, so the last owner is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NMST; i++) begin
            cand = IW'((int'(last) + 1 + i) % NMST);
            if (!found && elig[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign beat_sum    = {1'b0, beat_cnt} + {8'd0, bus.HTRANS[1]};
    assign limit_hit   = (maxbeats != 8'd0) && (beat_sum >= {1'b0, maxbeats});
    assign others      = |(elig & ~owner_bit);
    assign release_now = !bus.HBUSREQ[last] || !mask[last] || (limit_hit && others);

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        hmaster_nx  = hmaster;
        last_nx     = last;
        beat_cnt_nx = beat_cnt;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nx    = S_OWN;
                    grant_nx    = NMST'(1) << winner;
                    hmaster_nx  = 3'(winner);
                    last_nx     = winner;
                    beat_cnt_nx = 8'd0;
                end
            end
            S_OWN: begin
                if (bus.HREADY) begin
                    if (release_now) begin
                        beat_cnt_nx = 8'd0;
                        if (found) begin
                            grant_nx   = NMST'(1) << winner;
                            hmaster_nx = 3'(winner);
                            last_nx    = winner;
                        end else begin
                            state_nx = S_IDLE;
                            grant_nx = '0;
                        end
                    end else if (limit_hit) begin
                        beat_cnt_nx = 8'd0;
                    end else begin
                        beat_cnt_nx = beat_sum[8] ? 8'hFF : beat_sum[7:0];
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            grant    <= '0;
            hmaster  <= 3'd0;
            last     <= IW'(NMST - 1);
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            hmaster  <= hmaster_nx;
            last     <= last_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    // Config writes land on the same edge as arbitration, which still sees the old values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mask     <= '1;
            maxbeats <= 8'(DEF_MAXBEATS);
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                2'd0:    mask     <= bus.cfg_wdata[NMST-1:0];
                2'd1:    maxbeats <= bus.cfg_wdata[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.cfg_rdata = 32'd0;
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = 32'(mask);
            2'd1:    bus.cfg_rdata = {24'd0, maxbeats};
            2'd2:    bus.cfg_rdata = {20'd0, state, hmaster, 8'(grant)};
            default: bus.cfg_rdata = 32'd0;
        endcase
    end

    assign bus.HGRANT  = grant;
    assign bus.HMASTER = hmaster;
endmodule

// File: tb/tb_ahb_bm_arbiter.sv
// tb/tb_ahb_bm_arbiter.sv - self-checking bench for the bus-master arbiter
module tb_ahb_bm_arbiter;
    logic HCLK    = 1'b0;
    logic HRESETn = 1'b1;

    ahb_bm_arbiter_if #(.NMST(8)) bus ();

    ahb_bm_arbiter #(.NMST(8), .DEF_MAXBEATS(16)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_err = 0;
    int n_chk = 0;

    // Reference: owner -1 means nobody holds the bus.
    int         m_owner;
    int         m_last;
    int         m_hm;
    int         m_beats;
    int         m_max;
    logic [7:0] m_mask;

    typedef struct {
        logic [7:0]  req;
        logic [1:0]  trans;
        logic        rdy;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  eg;
        logic [2:0]  em;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [7:0] e, input int from);
        logic [2:0] j;
        for (int k = 1; k <= 8; k++) begin
            j = 3'((from + k) % 8);
            if (e[j]) return int'(j);
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_grant();
        logic [7:0] g;
        g = 8'd0;
        if (m_owner >= 0) g[3'(m_owner)] = 1'b1;
        return g;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_mask};
            2'd1:    return 32'(m_max);
            2'd2:    return {20'd0, (m_owner >= 0) ? 2'b01 : 2'b00, 3'(m_hm), exp_grant()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_hm    = 0;
        m_beats = 0;
        m_max   = 16;
        m_mask  = 8'hFF;
    endtask

    task automatic model_step();
        logic [7:0] e;
        logic [7:0] onehot;
        logic [2:0] ow;
        int         w;
        int         sum;
        bit         lim;
        bit         rel;
        e = bus.HBUSREQ & m_mask;
        if (m_owner < 0) begin
            w = rr(e, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_hm = w; m_beats = 0;
            end
        end else if (bus.HREADY) begin
            ow     = 3'(m_owner);
            onehot = 8'd0;
            onehot[ow] = 1'b1;
            sum = m_beats + (bus.HTRANS[1] ? 1 : 0);
            lim = (m_max != 0) && (sum >= m_max);
            rel = !bus.HBUSREQ[ow] || !m_mask[ow] || (lim && ((e & ~onehot) != 8'd0));
            if (rel) begin
                m_beats = 0;
                w = rr(e, m_last);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_hm = w;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_beats = lim ? 0 : ((sum > 255) ? 255 : sum);
            end
        end
        if (bus.cfg_we) begin
            if (bus.cfg_addr == 2'd0) m_mask = bus.cfg_wdata[7:0];
            if (bus.cfg_addr == 2'd1) m_max  = int'(bus.cfg_wdata[7:0]);
        end
    endtask

    task automatic drive(input logic [7:0] req, input logic [1:0] trans, input logic rdy,
                         input logic we, input logic [1:0] addr, input logic [31:0] wdata);
        bus.HBUSREQ   = req;
        bus.HTRANS    = trans;
        bus.HREADY    = rdy;
        bus.cfg_we    = we;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wdata;
    endtask

    task automatic cycle();
        model_step();
        @(posedge HCLK);
        #1;
        chk("grant", 32'(bus.HGRANT), 32'(exp_grant()));
        chk("hmaster", 32'(bus.HMASTER), 32'(m_hm));
        chk("rdata", bus.cfg_rdata, exp_rdata(bus.cfg_addr));
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.HGRANT), 32'd0);
        chk("rst_hmaster", 32'(bus.HMASTER), 32'd0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    initial begin
        drive(8'h00, 2'b00, 1'b1, 1'b0, 2'd2, 32'd0);
        model_reset();
        #3;
        do_reset();
        bus.cfg_addr = 2'd0;
        #1;
        chk("rst_mask", bus.cfg_rdata, 32'h0000_00FF);
        bus.cfg_addr = 2'd1;
        #1;
        chk("rst_maxbeats", bus.cfg_rdata, 32'd16);

        // Directed table: basic grant/release, HREADY freeze, then 4-beat alternation.
        tbl.push_back('{8'h05, 2'b10, 1'b1, 1'b0, 2'd2, 32'd0, 8'h01, 3'd0});
        tbl.push_back('{8'h04, 2'b10, 1'b1, 1'b0, 2'd2, 32'd0, 8'h04, 3'd2});
        tbl.push_back('{8'h04, 2'b10, 1'b0, 1'b0, 2'd2, 32'd0, 8'h04, 3'd2});
        tbl.push_back('{8'h00, 2'b10, 1'b0, 1'b0, 2'd2, 32'd0, 8'h04, 3'd2});
        tbl.push_back('{8'h00, 2'b10, 1'b1, 1'b0, 2'd2, 32'd0, 8'h00, 3'd2});
        tbl.push_back('{8'h00, 2'b10, 1'b1, 1'b0, 2'd2, 32'd0, 8'h00, 3'd2});
        tbl.push_back('{8'h03, 2'b11, 1'b1, 1'b1, 2'd1, 32'd4, 8'h01, 3'd0});
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++)
                tbl.push_back('{8'h03, 2'b11, 1'b1, 1'b0, 2'd2, 32'd0,
                                (r % 2 == 0) ? 8'h01 : 8'h02, (r % 2 == 0) ? 3'd0 : 3'd1});
            tbl.push_back('{8'h03, 2'b11, 1'b1, 1'b0, 2'd2, 32'd0,
                            (r % 2 == 0) ? 8'h02 : 8'h01, (r % 2 == 0) ? 3'd1 : 3'd0});
        end
        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].trans, tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            cycle();
            chk($sformatf("tbl%0d_grant", i), 32'(bus.HGRANT), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_hmaster", i), 32'(bus.HMASTER), 32'(tbl[i].em));
        end

        // Lone requester wraps its beat count at the limit, so a late rival waits 4 beats.
        do_reset();
        drive(8'h08, 2'b11, 1'b1, 1'b1, 2'd1, 32'd4);
        cycle();
        for (int k = 0; k < 8; k++) begin
            drive(8'h08, 2'b11, 1'b1, 1'b0, 2'd2, 32'd0);
            cycle();
            chk("solo_hold", 32'(bus.HGRANT), 32'h08);
        end
        for (int k = 0; k < 3; k++) begin
            drive(8'h09, 2'b11, 1'b1, 1'b0, 2'd2, 32'd0);
            cycle();
            chk("wrap_hold", 32'(bus.HGRANT), 32'h08);
        end
        cycle();
        chk("wrap_release", 32'(bus.HGRANT), 32'h01);

        // Owner masked off while the slave stalls; release waits for HREADY.
        do_reset();
        drive(8'h04, 2'b10, 1'b1, 1'b0, 2'd2, 32'd0);
        cycle();
        chk("own2", 32'(bus.HGRANT), 32'h04);
        drive(8'h05, 2'b11, 1'b0, 1'b1, 2'd0, 32'h0000_00FB);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("mask_stall_hold", 32'(bus.HGRANT), 32'h04);
        end
        bus.HREADY = 1'b1;
        cycle();
        chk("mask_release", 32'(bus.HGRANT), 32'h01);
        drive(8'h04, 2'b11, 1'b1, 1'b0, 2'd2, 32'd0);
        cycle();
        chk("mask_idle", 32'(bus.HGRANT), 32'h00);

        // Every master requesting with a one-beat limit rotates through all of them.
        do_reset();
        drive(8'hFF, 2'b11, 1'b1, 1'b1, 2'd1, 32'd1);
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("rot_grant", 32'(bus.HGRANT), 32'h1 << (k % 8));
            bus.cfg_addr = 2'd2;
            #1;
            chk("rot_status", bus.cfg_rdata, {20'd0, 2'b01, 3'(k % 8), 8'h1 << (k % 8)});
        end

        // Reset mid-tenure, then the first grant goes to master 7.
        drive(8'h01, 2'b11, 1'b1, 1'b0, 2'd2, 32'd0);
        cycle();
        do_reset();
        drive(8'h80, 2'b10, 1'b1, 1'b0, 2'd2, 32'd0);
        cycle();
        chk("post_rst_grant", 32'(bus.HGRANT), 32'h80);
        chk("post_rst_hmaster", 32'(bus.HMASTER), 32'd7);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            logic [7:0]  req;
            logic        we;
            logic [1:0]  addr;
            logic [31:0] wd;
            req  = 8'($urandom) & 8'($urandom);
            we   = ($urandom_range(0, 19) == 0);
            addr = 2'($urandom);
            wd   = (addr == 2'd1) ? 32'($urandom_range(0, 5)) : ($urandom | 32'h0000_0011);
            drive(req, 2'($urandom), ($urandom_range(0, 3) != 0), we, addr, wd);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
